vram_wr_arbiter: RTL and testbench
==================================

VRAM_WR_ARBITER -- requirements
Module: vram_wr_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 RSTN  in  1  asynchronous active-low reset.
REQ-004 cpu_req  in  1  CPU single-word VRAM write request; level, held with addr/data until cpu_ack.
REQ-005 cpu_addr  in  13  CPU target VRAM word address.
REQ-006 cpu_data  in  16  CPU write data.
REQ-007 cpu_ack  out  1  one-cycle pulse; high in the cycle the CPU word is driven to VRAM.
REQ-008 dbg_start  in  1  one-cycle pulse; starts a 32-word debug line burst.
REQ-009 dbg_line  in  8  debug line index, sampled with dbg_start.
REQ-010 dbg_data  in  512  debug line payload, sampled with dbg_start; word k = bits [16k+15:16k].
REQ-011 dbg_busy  out  1  high while a debug burst is pending.
REQ-012 dbg_done  out  1  one-cycle pulse with the final (k=31) debug write.
REQ-013 vram_we  out  1  VRAM port-A write enable, registered.
REQ-014 vram_addr  out  13  VRAM port-A word address, registered.
REQ-015 vram_din  out  16  VRAM port-A write data, registered.

Function
REQ-016 The block SHALL be a two-requester scheduler for the single VRAM write port; at most one write per cycle.
REQ-017 States SHALL be: IDLE (no burst), BURST (dbg_busy=1, beat counter k 0..31).
REQ-018 Grant decision SHALL occur in cycle T; the write (vram_we=1, addr, din, and cpu_ack or beat) SHALL appear registered in cycle T+1; latency one cycle.
REQ-019 The CPU SHALL NOT be granted in a cycle where cpu_ack=1; back-to-back CPU writes take at least two cycles each.
REQ-020 CPU write: vram_addr=cpu_addr, vram_din=cpu_data.
REQ-021 dbg_start in IDLE SHALL capture dbg_line/dbg_data and set k=0, dbg_busy=1 next cycle; dbg_start in BURST SHALL be ignored.
REQ-022 Debug beat k: vram_addr={line,k[4:0]}, vram_din=word k; k increments only on an issued beat.
REQ-023 Beat k=31 SHALL assert dbg_done in its write cycle; dbg_busy SHALL fall the following cycle; state returns to IDLE.
REQ-024 A cycle with no grant SHALL drive vram_we=0; vram_addr/vram_din hold last values.
REQ-025 Simultaneous dbg_start and cpu_req in IDLE: CPU granted; burst captured in the same cycle and begins next eligible cycle.
REQ-026 Arbitration policy between cpu_req and a pending beat SHALL follow the Configuration section.

Reset
REQ-027 RSTN low SHALL immediately force IDLE, k=0, vram_we=0, vram_addr=0, vram_din=0, cpu_ack=0, dbg_busy=0, dbg_done=0.
REQ-028 Reset mid-burst SHALL abort the burst with no dbg_done; remaining words SHALL NOT be written after release.

Configuration
REQ-029 Macro VRAM_ARB_FAIR_EN defined: when both contend, the requester not granted most recently wins (alternation; last-winner flag reset to DBG so CPU wins first contention).
REQ-030 Macro VRAM_ARB_FAIR_EN undefined: CPU has strict priority; beats issue only when CPU not eligible (cpu_req=0 or ack-gap cycle).

Verification
REQ-031 Idle, cpu_req=1 addr=0x0ABC data=0x1234 -> next cycle vram_we=1, vram_addr=0x0ABC, vram_din=0x1234, cpu_ack=1; exactly one write.
REQ-032 dbg_start, dbg_line=0x05, word k=0x1000+k, no CPU -> 32 consecutive writes addr 0x00A0..0x00BF data 0x1000..0x101F; dbg_done with last; dbg_busy low 34 cycles after start.
REQ-033 Burst active, cpu_req held continuously -> FAIR_EN: CPU and beats interleave, 32 beats complete; non-FAIR: CPU writes every other cycle, beats fill ack-gap cycles only.
REQ-034 dbg_start pulsed again at beat 10 with different line -> ignored; original 32 words only, one dbg_done.
REQ-035 RSTN low at beat 15 for 2 cycles -> all outputs 0 immediately; no further writes, no dbg_done after release.

Source files
------------

// File: rtl/vram_wr_arbiter.sv
// Single-port VRAM write scheduler: CPU single-word writes vs. 32-word debug line bursts.
// Define VRAM_ARB_FAIR_EN for alternating arbitration; default build gives the CPU strict priority.
module vram_wr_arbiter (
    input  logic         clk,
    input  logic         RSTN,
    input  logic         cpu_req,
    input  logic [12:0]  cpu_addr,
    input  logic [15:0]  cpu_data,
    output logic         cpu_ack,
    input  logic         dbg_start,
    input  logic [7:0]   dbg_line,
    input  logic [511:0] dbg_data,
    output logic         dbg_busy,
    output logic         dbg_done,
    output logic         vram_we,
    output logic [12:0]  vram_addr,
    output logic [15:0]  vram_din
);
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    logic         state_q, state_d;
    logic [5:0]   k_q, k_d;
    logic [7:0]   line_q, line_d;
    logic [511:0] data_q, data_d;
    logic         cpu_ack_q, cpu_ack_d;
    logic         we_q, we_d;
    logic [12:0]  addr_q, addr_d;
    logic [15:0]  din_q, din_d;
    logic         done_q, done_d;

    logic         cpu_elig, beat_elig, grant_cpu, grant_beat;
    logic [15:0]  beat_word;

    // k reaches 32 after the final beat is granted; busy stays up one more cycle for that write
    assign cpu_elig  = cpu_req & ~cpu_ack_q;
    assign beat_elig = (state_q == ST_BURST) & ~k_q[5];
    assign beat_word = data_q[{k_q[4:0], 4'b0000} +: 16];

`ifdef VRAM_ARB_FAIR_EN
    logic last_cpu_q, last_cpu_d;

    assign grant_cpu  = cpu_elig & (~beat_elig | ~last_cpu_q);
    assign last_cpu_d = grant_cpu ? 1'b1 : (grant_beat ? 1'b0 : last_cpu_q);

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            last_cpu_q <= 1'b0;
        end else begin
            last_cpu_q <= last_cpu_d;
        end
    end
`else
    assign grant_cpu = cpu_elig;
`endif
    assign grant_beat = beat_elig & ~grant_cpu;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        line_d    = line_q;
        data_d    = data_q;
        cpu_ack_d = grant_cpu;
        we_d      = grant_cpu | grant_beat;
        addr_d    = addr_q;
        din_d     = din_q;
        done_d    = grant_beat & (k_q[4:0] == 5'd31);

        if (grant_cpu) begin
            addr_d = cpu_addr;
            din_d  = cpu_data;
        end else if (grant_beat) begin
            addr_d = {line_q, k_q[4:0]};
            din_d  = beat_word;
            k_d    = k_q + 6'd1;
        end

        if (state_q == ST_IDLE) begin
            if (dbg_start) begin
                state_d = ST_BURST;
                k_d     = '0;
                line_d  = dbg_line;
                data_d  = dbg_data;
            end
        end else if (k_q[5]) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            line_q    <= '0;
            data_q    <= '0;
            cpu_ack_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            line_q    <= line_d;
            data_q    <= data_d;
            cpu_ack_q <= cpu_ack_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            done_q    <= done_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dbg_busy  = (state_q == ST_BURST);
    assign dbg_done  = done_q;
    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_din  = din_q;
endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Self-checking bench for vram_wr_arbiter: queue-based reference model plus directed scenarios.
module tb_vram_wr_arbiter;
    logic         clk = 1'b0;
    logic         RSTN;
    logic         cpu_req;
    logic [12:0]  cpu_addr;
    logic [15:0]  cpu_data;
    logic         cpu_ack;
    logic         dbg_start;
    logic [7:0]   dbg_line;
    logic [511:0] dbg_data;
    logic         dbg_busy, dbg_done, vram_we;
    logic [12:0]  vram_addr;
    logic [15:0]  vram_din;

    vram_wr_arbiter dut (
        .clk(clk), .RSTN(RSTN),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .dbg_start(dbg_start), .dbg_line(dbg_line), .dbg_data(dbg_data),
        .dbg_busy(dbg_busy), .dbg_done(dbg_done),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending burst words kept as a queue of (addr,data) writes.
    typedef struct packed { logic [12:0] a; logic [15:0] d; } wr_t;
    wr_t         bq[$];
    bit          m_we, m_ack, m_done, m_busy, m_last_cpu;
    logic [12:0] m_addr;
    logic [15:0] m_din;
    bit          cpu_ok, beat_ok, g_cpu, g_beat, nxt_busy;
    wr_t         w;

    always @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            bq.delete();
            m_we = 0; m_ack = 0; m_done = 0; m_busy = 0; m_last_cpu = 0;
            m_addr = '0; m_din = '0;
        end else begin
            cpu_ok  = cpu_req && !m_ack;
            beat_ok = m_busy && (bq.size() > 0);
            if (cpu_ok && beat_ok) begin
`ifdef VRAM_ARB_FAIR_EN
                g_cpu = !m_last_cpu;
`else
                g_cpu = 1;
`endif
                g_beat = !g_cpu;
            end else begin
                g_cpu  = cpu_ok;
                g_beat = beat_ok;
            end
            nxt_busy = m_busy ? !m_done : dbg_start;
            if (!m_busy && dbg_start)
                for (int k = 0; k < 32; k++)
                    bq.push_back('{a: {dbg_line, 5'(k)}, d: dbg_data[16*k +: 16]});
            m_done = 0;
            if (g_cpu) begin
                m_we = 1; m_ack = 1; m_addr = cpu_addr; m_din = cpu_data; m_last_cpu = 1;
            end else if (g_beat) begin
                w = bq.pop_front();
                m_we = 1; m_ack = 0; m_addr = w.a; m_din = w.d; m_last_cpu = 0;
                m_done = (bq.size() == 0);
            end else begin
                m_we = 0; m_ack = 0;
            end
            m_busy = nxt_busy;
        end
    end

    typedef struct { logic [12:0] a; logic [15:0] d; int c; } log_t;
    log_t log_q[$];
    int   n_done = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("we", {31'd0, vram_we}, {31'd0, m_we});
        chk("ack", {31'd0, cpu_ack}, {31'd0, m_ack});
        chk("busy", {31'd0, dbg_busy}, {31'd0, m_busy});
        chk("done", {31'd0, dbg_done}, {31'd0, m_done});
        chk("addr", {19'd0, vram_addr}, {19'd0, m_addr});
        chk("din", {16'd0, vram_din}, {16'd0, m_din});
        if (vram_we) log_q.push_back('{a: vram_addr, d: vram_din, c: cyc});
        if (dbg_done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] line, input logic [15:0] base);
        dbg_start = 1'b1;
        dbg_line  = line;
        for (int k = 0; k < 32; k++) dbg_data[16*k +: 16] = base + 16'(k);
    endtask

    int s, d0, ncpu, nbeat, nbad;

    initial begin
        RSTN = 1'b0; cpu_req = 0; cpu_addr = '0; cpu_data = '0;
        dbg_start = 0; dbg_line = '0; dbg_data = '0;
        step(2);
        chk("rst_we", {31'd0, vram_we}, 32'd0);
        chk("rst_addr", {19'd0, vram_addr}, 32'd0);
        chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
        RSTN = 1'b1;
        step(2);

        // single CPU write
        log_q.delete();
        cpu_req = 1; cpu_addr = 13'h0ABC; cpu_data = 16'h1234;
        step(1);
        cpu_req = 0;
        @(negedge clk);
        chk("cpu_we", {31'd0, vram_we}, 32'd1);
        chk("cpu_addr", {19'd0, vram_addr}, 32'h0ABC);
        chk("cpu_din", {16'd0, vram_din}, 32'h1234);
        chk("cpu_ack", {31'd0, cpu_ack}, 32'd1);
        step(3);
        chk("cpu_nwr", log_q.size(), 32'd1);
        chk("hold_addr", {19'd0, vram_addr}, 32'h0ABC);

        // plain burst
        log_q.delete(); d0 = n_done;
        start_burst(8'h05, 16'h1000); s = cyc;
        step(1);
        dbg_start = 0;
        step(32);
        @(negedge clk);
        chk("b_busy33", {31'd0, dbg_busy}, 32'd1);
        chk("b_done33", {31'd0, dbg_done}, 32'd1);
        step(1);
        @(negedge clk);
        chk("b_busy34", {31'd0, dbg_busy}, 32'd0);
        step(2);
        chk("b_nwr", log_q.size(), 32'd32);
        chk("b_first_a", {19'd0, log_q[0].a}, 32'h00A0);
        chk("b_first_d", {16'd0, log_q[0].d}, 32'h1000);
        chk("b_first_c", log_q[0].c, s + 2);
        chk("b_last_a", {19'd0, log_q[31].a}, 32'h00BF);
        chk("b_last_d", {16'd0, log_q[31].d}, 32'h101F);
        chk("b_last_c", log_q[31].c, s + 33);
        chk("b_ndone", n_done - d0, 32'd1);

        // burst with CPU held throughout, started together with the CPU request
        log_q.delete(); d0 = n_done;
        cpu_req = 1; cpu_addr = 13'h1FFF; cpu_data = 16'hBEEF;
        start_burst(8'h12, 16'h5500); s = cyc;
        step(1);
        dbg_start = 0;
        step(78);
        cpu_req = 0;
        step(4);
        ncpu = 0; nbeat = 0;
        foreach (log_q[i]) begin
            if (log_q[i].a == 13'h1FFF) ncpu++;
            else if (log_q[i].a[12:5] == 8'h12) nbeat++;
        end
        chk("mix_ncpu", ncpu, 32'd40);
        chk("mix_nbeat", nbeat, 32'd32);
        chk("mix_first_c", log_q[0].c, s + 1);
        chk("mix_beat0_a", {19'd0, log_q[1].a}, 32'h0240);
        chk("mix_beat0_d", {16'd0, log_q[1].d}, 32'h5500);
        chk("mix_ndone", n_done - d0, 32'd1);

        // second start mid-burst is ignored
        log_q.delete(); d0 = n_done;
        start_burst(8'h07, 16'h2000);
        step(1);
        dbg_start = 0;
        step(10);
        start_burst(8'h33, 16'h4000);
        step(1);
        dbg_start = 0;
        step(40);
        nbad = 0;
        foreach (log_q[i]) if (log_q[i].a[12:5] != 8'h07) nbad++;
        chk("ign_nwr", log_q.size(), 32'd32);
        chk("ign_bad", nbad, 32'd0);
        chk("ign_b10_a", {19'd0, log_q[10].a}, 32'h00EA);
        chk("ign_last_d", {16'd0, log_q[31].d}, 32'h201F);
        chk("ign_ndone", n_done - d0, 32'd1);

        // reset in the middle of a burst
        start_burst(8'h09, 16'h3000);
        step(1);
        dbg_start = 0;
        step(16);
        chk("b15_we", {31'd0, vram_we}, 32'd1);
        chk("b15_addr", {19'd0, vram_addr}, 32'h012F);
        chk("b15_din", {16'd0, vram_din}, 32'h300F);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_we", {31'd0, vram_we}, 32'd0);
        chk("arst_addr", {19'd0, vram_addr}, 32'd0);
        chk("arst_din", {16'd0, vram_din}, 32'd0);
        chk("arst_busy", {31'd0, dbg_busy}, 32'd0);
        log_q.delete(); d0 = n_done;
        step(2);
        RSTN = 1'b1;
        step(40);
        chk("post_nwr", log_q.size(), 32'd0);
        chk("post_ndone", n_done - d0, 32'd0);
        chk("post_busy", {31'd0, dbg_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
